seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Parametrised multiplexed seven-segment driver: time-multiplexes `DIGITS` hex nibbles onto a common segment bus with one active-low anode per digit. Adds frame-coherent input snapshot, per-digit decimal points, an anti-ghosting blank interval and a frame-done pulse. Sits between the core's debug/status value and the board's LED digits, clocked from the system clock.

## Interface
- `DIGITS`, 4: number of digits, legal range 1..8.
- `DIV`, 50: clock cycles per digit slot, ≥ 2.
- `BLANK`, 2: cycles at the start of each slot with all anodes off, 0 ≤ BLANK < DIV.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `on`  in  1  display enable; 0 forces all digits dark.
- `number`  in  4*DIGITS  hex value; nibble `DIGITS-1` is the most significant and the leftmost digit.
- `dp`  in  DIGITS  decimal point per digit; bit k pairs with nibble k; 1 = lit.
- `an`  out  DIGITS  anode selects, active-low, at most one low.
- `seg`  out  8  {dp, g, f, e, d, c, b, a}, all active-low.
- `frame_done`  out  1  one-cycle pulse per completed scan frame.

## Operation
- Prescaler `cnt` counts 0..DIV-1 and wraps. Digit index `idx` advances when `cnt == DIV-1`; it wraps from DIGITS-1 to 0. There is no out-of-range index.
- Scan order runs from the most significant digit to the least significant. When `idx = i`, it drives nibble `DIGITS-1-i` and anode bit `DIGITS-1-i`.
- Snapshot: `number` and `dp` are captured into internal registers on the cycle where `idx` wraps to 0. `frame_done` pulses on the same cycle. Mid-frame changes to the inputs are never displayed.
- Slot phases:
  - BLANK phase, while `cnt < BLANK`: `an` is all ones and `seg` = 8'hFF.
  - DRIVE phase, for the rest of the slot: the selected anode is low and `seg` carries the decoded nibble plus `~dp`.
- Hex decode covers the full 0..F range (A b C d E F). Examples: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 8→80, F→8E, each with dp off.
- `on = 0`: `an` is all ones and `seg` = 8'hFF. The counters, snapshot and `frame_done` keep running, so re-enabling resumes the scan in phase.
- Reset (async, any cycle, including mid-frame):
  - `cnt`, `idx` and the snapshot clear to 0.
  - `an` is all ones, `seg` = 8'hFF, `frame_done` = 0.
  - The first snapshot is taken at the first wrap of `idx` after reset.

## Timing
- `an`, `seg` and `frame_done` are registered. They reflect `cnt`/`idx`/snapshot with 1-cycle latency.
- Each slot is DIV cycles long, with BLANK dark cycles followed by DIV-BLANK lit cycles.
- A frame is DIGITS*DIV cycles. `frame_done` has exactly that period while out of reset.
- Deasserting `on` darkens the outputs on the next edge. Reasserting it lights them on the next edge, provided the scan is in a DRIVE phase.
- At no edge are two anodes low at once. An anode change always passes through at least BLANK all-off cycles; when BLANK = 0 the change is direct.

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN`
  - Defined: a digit is kept dark when its snapshot nibble is 0 and all more-significant nibbles are also 0. It stays dark for its whole slot (anode high, `seg` FF, dp ignored). The least significant digit is always shown.
  - Undefined: every digit is driven, and zero digits show C0.

## Structure
- Package `seg_pkg`:
  - the 16-entry active-low segment constant table,
  - `SEG_OFF = 8'hFF`,
  - the anode all-off helper.
- Sub-module `seg_hex_decoder`: a combinational 4-bit nibble to 7-bit active-low segment decoder that uses the package table. It is instantiated once, on the muxed nibble.
- Top level contains the prescaler, index counter, snapshot registers, phase logic, optional leading-zero mask, and output registers.

## Test plan
Unless stated otherwise, DIGITS=4, DIV=4, BLANK=1.

- **Reset:** hold `rst_n` = 0, then release with `number` = 16'h1234, `on` = 1.
  - `an` = F and `seg` = FF during reset.
  - The first `frame_done` arrives 16 cycles later.
- **Scan:** `number` = 16'h1234, after the first snapshot.
  - Each slot is 1 dark cycle, then 3 cycles of 0111/F9, 1011/A4, 1101/B0, 1110/99.
  - `frame_done` pulses every 16 cycles.
- **Snapshot coherence:** change `number` to 16'h5555 mid-frame.
  - The current frame still shows 1234.
  - 5555 (all 92) appears only after the next `frame_done`.
- **Enable and decimal point:** `dp` = 4'b0010, toggle `on`.
  - `on` = 0 gives `an` = F, `seg` = FF on the next edge.
  - Re-enabling resumes with the same phase.
  - `seg[7]` is low only while `an` = 1101.
- **Leading zero, macro defined:**
  - `number` = 16'h0050 lights only anodes 1101 (92) and 1110 (C0).
  - `number` = 16'h0000 lights only 1110 (C0).
  - Rerun without the macro: all four digits are lit.
- **Mid-frame reset:** pulse `rst_n` low during slot 2.
  - `an` = F and `seg` = FF immediately, without waiting for a clock edge.
  - After release, the scan restarts at the leftmost digit, and `frame_done` arrives 16 cycles after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: active-low segment
// table, dark-segment value and anode helpers.
package seg_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry n is the {g,f,e,d,c,b,a} active-low pattern for nibble value n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [MAX_DIGITS-1:0] an_all_off();
        return '1;
    endfunction

    function automatic logic [MAX_DIGITS-1:0] an_select_n(input logic [2:0] pos);
        return ~(MAX_DIGITS'(1) << pos);
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Value/enable inputs and LED-digit outputs of seg_scan_display, bundled with
// modports for the driving core (master) and the display block (slave).
interface seg_scan_display_if #(
    parameter int DIGITS = 4
);
    import seg_pkg::*;

    logic                  on;
    logic [4*DIGITS-1:0]   number;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     an;
    logic [7:0]            seg;
    logic                  frame_done;

    modport master (
        output on, number, dp,
        input  an, seg, frame_done
    );

    modport slave (
        input  on, number, dp,
        output an, seg, frame_done
    );

endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-low {g..a} segment decoder, full 0..F range.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with frame snapshot, blank interval and
// frame-done pulse. Optional leading-zero blanking: SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50,
    parameter int BLANK  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_display_if.slave bus
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [DIGITS-1:0][3:0]     snap_num_q, snap_num_d;
    logic [DIGITS-1:0]          snap_dp_q, snap_dp_d;
    logic [DIGITS-1:0]          an_q, an_d;
    logic [7:0]                 seg_q, seg_d;
    logic                       frame_done_q, frame_done_d;

    logic                       slot_end;
    logic                       frame_end;
    logic [IDX_W-1:0]           pos;
    logic [3:0]                 cur_nib;
    logic                       cur_dp;
    logic [6:0]                 cur_seg7;
    logic                       blank_phase;
    logic                       digit_dark;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // Scan runs MSB first, so slot idx addresses nibble/anode DIGITS-1-idx.
    assign pos     = IDX_LAST - idx_q;
    assign cur_nib = snap_num_q[pos];
    assign cur_dp  = snap_dp_q[pos];

    seg_hex_decoder u_dec (
        .nibble (cur_nib),
        .seg_n  (cur_seg7)
    );

    generate
        if (BLANK > 0) begin : g_blank
            localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK);
            assign blank_phase = (cnt_q < BLANK_C);
        end else begin : g_no_blank
            assign blank_phase = 1'b0;
        end
    endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] nib_zero;
    logic [DIGITS-1:0] zero_above;
    logic              zero_run;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nib_zero
            assign nib_zero[gi] = (snap_num_q[gi] == 4'h0);
        end
    endgenerate

    // zero_above[k]: nibble k and every more-significant nibble are zero.
    always_comb begin
        zero_run   = 1'b1;
        zero_above = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run && nib_zero[k];
            zero_above[k] = zero_run;
        end
    end

    assign digit_dark = zero_above[pos] && (pos != '0);
`else
    assign digit_dark = 1'b0;
`endif

    always_comb begin
        cnt_d        = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        snap_num_d   = snap_num_q;
        snap_dp_d    = snap_dp_q;
        frame_done_d = frame_end;

        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        // Inputs are sampled only at the frame boundary so a frame is coherent.
        if (frame_end) begin
            snap_num_d = bus.number;
            snap_dp_d  = bus.dp;
        end

        if (!bus.on || blank_phase || digit_dark) begin
            an_d  = DIGITS'(an_all_off());
            seg_d = SEG_OFF;
        end else begin
            an_d  = DIGITS'(an_select_n(3'(pos)));
            seg_d = {~cur_dp, cur_seg7};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_num_q   <= '0;
            snap_dp_q    <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_num_q   <= snap_num_d;
            snap_dp_q    <= snap_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (DIGITS=4, DIV=4, BLANK=1); expectations
// adapt when SEG_LEADING_ZERO_BLANK_EN is defined.
module tb_seg_scan_display;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LIT_0050  = 4'b1100;
    localparam logic [3:0] LIT_0000  = 4'b1000;
    localparam logic [3:0] FIRST_AN  = 4'hF;
    localparam logic [7:0] FIRST_SEG = 8'hFF;
`else
    localparam logic [3:0] LIT_0050  = 4'b1111;
    localparam logic [3:0] LIT_0000  = 4'b1111;
    localparam logic [3:0] FIRST_AN  = 4'b0111;
    localparam logic [7:0] FIRST_SEG = 8'hC0;
`endif

    seg_scan_display_if #(.DIGITS(4)) bus_if ();

    seg_scan_display #(
        .DIGITS (4),
        .DIV    (4),
        .BLANK  (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame following a reset: snapshot is still zero, frame_done on the 16th edge.
    task automatic wait_first_done(input string name);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            check_eq($sformatf("%s_fd%0d", name, n), 32'(bus_if.frame_done), 32'(n == 16));
            if (n == 2) begin
                check_eq($sformatf("%s_first_an", name), 32'(bus_if.an), 32'(FIRST_AN));
                check_eq($sformatf("%s_first_seg", name), 32'(bus_if.seg), 32'(FIRST_SEG));
            end
        end
    endtask

    // One 16-cycle frame; byte i of exp_segs is the pattern for slot i (MSB first).
    task automatic check_frame(input string name, input logic [31:0] exp_segs,
                               input logic [3:0] lit, input int poke_at,
                               input logic [15:0] poke_num, input logic [3:0] poke_dp,
                               input int off_from, input int off_to);
        int         c;
        int         ix;
        logic       lit_now;
        logic [3:0] sel;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            c       = (j - 1) % 4;
            ix      = (j - 1) / 4;
            lit_now = (c != 0) && lit[ix] && !(j > off_from && j <= off_to);
            sel     = 4'b1000 >> ix;
            exp_an  = lit_now ? ~sel : 4'hF;
            exp_seg = lit_now ? exp_segs[ix*8 +: 8] : 8'hFF;
            check_eq($sformatf("%s_an%0d", name, j), 32'(bus_if.an), 32'(exp_an));
            check_eq($sformatf("%s_seg%0d", name, j), 32'(bus_if.seg), 32'(exp_seg));
            check_eq($sformatf("%s_fd%0d", name, j), 32'(bus_if.frame_done), 32'(j == 16));
            $display("%s cyc %0d an %b seg %h fd %b", name, j, bus_if.an, bus_if.seg, bus_if.frame_done);
            if (j == poke_at) begin
                bus_if.number = poke_num;
                bus_if.dp     = poke_dp;
            end
            if (j == off_from) bus_if.on = 1'b0;
            if (j == off_to)   bus_if.on = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b1;
        bus_if.on     = 1'b1;
        bus_if.number = 16'h1234;
        bus_if.dp     = 4'b0000;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_an", 32'(bus_if.an), 32'hF);
        check_eq("rst_seg", 32'(bus_if.seg), 32'hFF);
        check_eq("rst_fd", 32'(bus_if.frame_done), 32'h0);
        rst_n = 1'b1;
        wait_first_done("rst1");

        check_frame("scan1234", 32'h99B0A4F9, 4'hF, -1, 16'h0, 4'h0, 0, 0);
        check_frame("coherent", 32'h99B0A4F9, 4'hF, 6, 16'h5555, 4'b0010, 0, 0);
        check_frame("show5555", 32'h92129292, 4'hF, -1, 16'h0, 4'h0, 0, 0);
        check_frame("enable", 32'h92129292, 4'hF, 15, 16'h0050, 4'b0000, 5, 10);
        check_frame("num0050", 32'hC092C0C0, LIT_0050, 15, 16'h0000, 4'b0000, 0, 0);
        check_frame("num0000", 32'hC0C0C0C0, LIT_0000, 15, 16'h1234, 4'b0000, 0, 0);
        check_frame("back1234", 32'h99B0A4F9, 4'hF, -1, 16'h0, 4'h0, 0, 0);

        repeat (10) @(negedge clk);
        check_eq("pre_rst_an", 32'(bus_if.an), 32'hD);
        check_eq("pre_rst_seg", 32'(bus_if.seg), 32'hB0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_an", 32'(bus_if.an), 32'hF);
        check_eq("async_rst_seg", 32'(bus_if.seg), 32'hFF);
        check_eq("async_rst_fd", 32'(bus_if.frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_first_done("rst2");
        check_frame("restart", 32'h99B0A4F9, 4'hF, -1, 16'h0, 4'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
